// File: rtl/mux4_sel_arbiter.sv
// mux4_sel_arbiter
// Round-robin scheduler that drives the select lines of a downstream 4-to-1 mux.
// Four level-sensitive requests are arbitrated starting after the last winner.
// The winner index is registered onto {s1,s0}, together with a one-hot grant
// and a valid flag. A slice counter stops a channel from holding the mux
// forever while other channels are waiting. Every release is followed by
// exactly one idle cycle before the next grant.
module mux4_sel_arbiter #(
    parameter int MAX_SLICE = 8,  // grant cycles allowed while others wait (1 .. 2**CNT_W)
    parameter int CNT_W     = 4   // slice counter width
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       s0,
    output logic       s1,
    output logic [3:0] grant,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Terminal count of the slice counter. The counter also saturates here
    // when the holder is the only requester.
    localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(MAX_SLICE - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;    // last winner; the search starts one past it
    logic [CNT_W-1:0] cnt_q,   cnt_d;    // grant cycles already used by the holder
    logic [1:0]       sel_q,   sel_d;    // registered mux select {s1,s0}
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;

    logic [1:0]       win_idx;
    logic             others_req;
    logic             rel_now;

    // Rotating priority search: ptr+1, ptr+2, ptr+3, ptr+4 (mod 4). The first set bit wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        found   = 1'b0;
        win_idx = ptr_q;
        idx     = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Release conditions for the current holder. The holder is always ptr_q while in GRANT.
    always_comb begin
        others_req = |(req & ~grant_q);
        rel_now    = done || !req[ptr_q] || ((cnt_q == SLICE_LAST) && others_req);
    end

    // State register plus all registered datapath and outputs; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the values from before the edge and the result
            // does not depend on the order of the statements.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: leave IDLE on any request. Leave GRANT on any release
    // cause. Several causes in the same cycle still give a single transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req)   state_d = GRANT;
            GRANT:   if (rel_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values. Outputs only change on an arbitration
    // or a release. The select lines keep their last value across the gap.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    valid_d = 1'b1;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end else begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (rel_now) begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != SLICE_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign grant = grant_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Directed bench for mux4_sel_arbiter. The main instance uses MAX_SLICE=8 and
// a second instance uses MAX_SLICE=1. Inputs are driven 1 ns after the rising
// edge, and outputs are checked at the same point. Each check compares the
// packed tuple {valid, grant, s1, s0} against a hand-computed value.
module tb_mux4_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req,  req1;
    logic       done, done1;
    logic       s0, s1, valid;
    logic [3:0] grant;
    logic       s0_1, s1_1, valid_1;
    logic [3:0] grant_1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux4_sel_arbiter #(.MAX_SLICE(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .s0(s0), .s1(s1), .grant(grant), .valid(valid)
    );

    mux4_sel_arbiter #(.MAX_SLICE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .done(done1),
        .s0(s0_1), .s1(s1_1), .grant(grant_1), .valid(valid_1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; done = 1'b0; req1 = 4'b0; done1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_00) begin
            errors++; $display("FAIL reset_state: got %b want 0000000", {valid, grant, s1, s0});
        end
        req = 4'b0100;
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_0100_10) begin
            errors++; $display("FAIL reset_pregrant: got %b want 1010010", {valid, grant, s1, s0});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_00) begin
            errors++; $display("FAIL reset_async: got %b want 0000000", {valid, grant, s1, s0});
        end
        req = 4'b0010;
        @(negedge clk) rst = 1'b0;
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_0010_01) begin
            errors++; $display("FAIL reset_restart: got %b want 1001001", {valid, grant, s1, s0});
        end
        req = 4'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({valid, grant, s1, s0} !== 7'b1_0100_10) begin
                errors++; $display("FAIL single[%0d]: got %b want 1010010", i, {valid, grant, s1, s0});
            end
        end
        req = 4'b0;
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_10) begin
            errors++; $display("FAIL single_drop: got %b want 0000010", {valid, grant, s1, s0});
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 8; r++) begin
            exp_s = 2'(r);
            exp_g = 4'b0001 << exp_s;
            for (int i = 0; i < 8; i++) begin
                step();
                checks++;
                if ({valid, grant, s1, s0} !== {1'b1, exp_g, exp_s}) begin
                    errors++; $display("FAIL contention[%0d.%0d]: got %b want %b", r, i,
                                       {valid, grant, s1, s0}, {1'b1, exp_g, exp_s});
                end
            end
            step();
            checks++;
            if ({valid, grant, s1, s0} !== {1'b0, 4'b0000, exp_s}) begin
                errors++; $display("FAIL contention_gap[%0d]: got %b want %b", r,
                                   {valid, grant, s1, s0}, {1'b0, 4'b0000, exp_s});
            end
        end
        req = 4'b0;
    endtask

    task automatic test_done();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({valid, grant, s1, s0} !== 7'b1_0001_00) begin
                errors++; $display("FAIL done_ch0[%0d]: got %b want 1000100", i, {valid, grant, s1, s0});
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_00) begin
            errors++; $display("FAIL done_gap: got %b want 0000000", {valid, grant, s1, s0});
        end
        // ch1 gets a fresh slice of 8 cycles, then times out because ch0 still requests
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({valid, grant, s1, s0} !== 7'b1_0010_01) begin
                errors++; $display("FAIL done_ch1[%0d]: got %b want 1001001", i, {valid, grant, s1, s0});
            end
        end
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_01) begin
            errors++; $display("FAIL done_ch1_timeout: got %b want 0000001", {valid, grant, s1, s0});
        end
        req = 4'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 8; i++) step();   // after 8 grant cycles the counter sits at MAX_SLICE-1
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_0001_00) begin
            errors++; $display("FAIL simul_hold: got %b want 1000100", {valid, grant, s1, s0});
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_00) begin
            errors++; $display("FAIL simul_gap: got %b want 0000000", {valid, grant, s1, s0});
        end
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_0100_10) begin
            errors++; $display("FAIL simul_next: got %b want 1010010", {valid, grant, s1, s0});
        end
        req = 4'b0;
    endtask

    task automatic test_skip();
        do_reset();
        req = 4'b0010;
        step();                   // ch1 granted, ptr = 1
        req = 4'b1001;            // dropping req[1] releases the grant
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_01) begin
            errors++; $display("FAIL skip_gap: got %b want 0000001", {valid, grant, s1, s0});
        end
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_1000_11) begin
            errors++; $display("FAIL skip_ch3: got %b want 1100011", {valid, grant, s1, s0});
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_0001_00) begin
            errors++; $display("FAIL skip_wrap: got %b want 1000100", {valid, grant, s1, s0});
        end
        req = 4'b0;
    endtask

    task automatic test_idle_done_and_regrant();
        do_reset();
        done = 1'b1;
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_00) begin
            errors++; $display("FAIL idle_done: got %b want 0000000", {valid, grant, s1, s0});
        end
        req = 4'b1000;            // done still high in IDLE must not block this grant
        step();
        done = 1'b0;
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_1000_11) begin
            errors++; $display("FAIL idle_done_grant: got %b want 1100011", {valid, grant, s1, s0});
        end
        done = 1'b1;              // sole requester: gap, then the same channel again
        step();
        done = 1'b0;
        checks++;
        if ({valid, grant, s1, s0} !== 7'b0_0000_11) begin
            errors++; $display("FAIL regrant_gap: got %b want 0000011", {valid, grant, s1, s0});
        end
        step();
        checks++;
        if ({valid, grant, s1, s0} !== 7'b1_1000_11) begin
            errors++; $display("FAIL regrant_same: got %b want 1100011", {valid, grant, s1, s0});
        end
        req = 4'b0;
    endtask

    task automatic test_slice1();
        logic [6:0] exp [0:5];
        exp[0] = 7'b1_0001_00; exp[1] = 7'b0_0000_00; exp[2] = 7'b1_0010_01;
        exp[3] = 7'b0_0000_01; exp[4] = 7'b1_0001_00; exp[5] = 7'b0_0000_00;
        do_reset();
        req1 = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({valid_1, grant_1, s1_1, s0_1} !== exp[i]) begin
                errors++; $display("FAIL slice1[%0d]: got %b want %b", i,
                                   {valid_1, grant_1, s1_1, s0_1}, exp[i]);
            end
        end
        req1 = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_done();
        test_simultaneous();
        test_skip();
        test_idle_done_and_regrant();
        test_slice1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
